ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Parametrised multiplexed seven-segment display driver: scans `DIGITS` common-electrode digits in rotation, decodes one 4-bit hex nibble per digit to segments a–g plus decimal point, and drives a one-hot digit-select bus. It is the generalised successor to the fixed 4-digit counter/decoder scanner. It adds these features over that scanner:
- programmable refresh prescaler
- inter-digit dead time (anti-ghosting)
- leading-zero suppression
- frame-coherent double-buffered data update with a pending flag

It sits between the system datapath and the board display pads.

## Interface
Parameters:
- `DIGITS`, 4 — number of scanned digits; legal values 2..8.
- `PRESCALE`, 1000 — Clk cycles per digit slot; must be ≥ `DEAD`+2.
- `DEAD`, 8 — cycles at the start of each slot during which all COM lines are inactive; 0 is legal.
- `COM_ACTIVE_LOW`, 1 — 1: the selected COM line is driven 0; 0: the selected COM line is driven 1.

Ports:
- `Clk` in 1 — single clock; all state is on its rising edge.
- `Aclr` in 1 — reset, asynchronous and active-low.
- `data` in 4·DIGITS — hex nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- `dp` in DIGITS — decimal point request per digit.
- `load` in 1 — one-cycle strobe that captures `data`/`dp` into staging.
- `en` in 1 — display enable.
- `lz_en` in 1 — leading-zero suppression enable.
- `COM` out DIGITS — digit selects, one-hot active, polarity set by `COM_ACTIVE_LOW`.
- `seg` out 7 — segments, active-high; `seg[0]`=a … `seg[6]`=g.
- `dp_out` out 1 — decimal point segment, active-high.
- `pending` out 1 — staged data is not yet displayed.
- `frame_start` out 1 — one-cycle pulse at the start of digit 0.

## Operation
- Reset (Aclr=0), asynchronous:
  - prescaler=0, digit index=0, staging=0, display register=0, pending=0
  - `COM` all inactive, `seg`=0, `dp_out`=0, `frame_start`=0
- Prescaler counts 0..PRESCALE-1, then wraps to 0. At wrap, the digit index advances (i → i+1, with DIGITS-1 → 0).
- Slot timing: for prescaler counts 0..DEAD-1, `COM` is all inactive and `seg`/`dp_out` are 0. For the remaining counts, the COM bit of the current digit is active and `seg`/`dp_out` show that digit.
- Decode: standard hex glyphs 0–F from the display register (not from staging).
  - Examples: 0→7'h3F, 1→7'h06, 8→7'h7F, A→7'h77, F→7'h71.
- Leading-zero suppression (`lz_en`=1):
  - Digits from DIGITS-1 downward whose nibble is 0 have `seg` forced to 0, up to the first nonzero nibble.
  - Digit 0 is never suppressed.
  - `dp_out` of a suppressed digit is still driven from `dp`.
  - Evaluation uses the display register.
- Update handshake:
  - `load`=1 copies `data`/`dp` into staging and sets `pending`.
  - When the digit index wraps to 0 (frame boundary): if `pending`=1, staging is copied to the display register and `pending` clears in the same cycle.
  - A frame never mixes old and new data.
  - Repeated `load` strobes before the boundary overwrite staging; the last one wins.
- Simultaneous `load` and frame boundary: the new `data`/`dp` go straight to both staging and the display register; `pending` stays 0.
- `en`=0:
  - Prescaler and digit index are held at 0; outputs are blanked as in dead time.
  - Staging and `load` still function; `pending` holds.
  - On `en` 0→1, scanning restarts at digit 0, count 0. This restart is a frame boundary, so `frame_start` pulses and pending data transfers.

## Timing
- All outputs are registered: the output reflects the prescaler/index state of the previous cycle (latency 1).
- `frame_start` is high for exactly one cycle, asserted the cycle after the index wraps to 0.
- `pending` rises the cycle after `load` and falls the cycle after the boundary.
- Refresh period = DIGITS·PRESCALE cycles.
- Width rules:
  - Prescaler width is clog2(PRESCALE).
  - Index width is clog2(DIGITS), minimum 1.
  - There is no overflow beyond the wrap points.
- Reset mid-slot forces the reset values immediately; scanning resumes at digit 0, count 0 on the first edge after `Aclr` deasserts.

## Structure
- Package `ssd_pkg`:
  - 16-entry hex-to-segment constant table
  - segment bit index constants A..G
  - a `COM_INACTIVE` helper for each polarity
- Sub-module `ssd_hex_decoder`: combinational nibble → 7 segments, with a blank input.
- Top level holds the prescaler, digit index, staging/display registers, suppression scan and output registers.

## Test plan
All scenarios use DIGITS=4, PRESCALE=16, DEAD=2, COM_ACTIVE_LOW=1 unless noted.
- Reset, then `en`=1, `data`=16'h1234 loaded: per slot, COM=4'b1111 for 2 cycles, then 4'b1110 with seg=7'h66 ("4") for 14 cycles; digits 1/2/3 show 3/2/1; period 64 cycles.
- `load` 16'h00A5 mid-frame: `pending`=1 until the next `frame_start`; the old value is shown for the rest of the frame; the new value is shown from digit 0, after which `pending`=0.
- `lz_en`=1, `data`=16'h0005: digits 3 and 2 give seg=0; digit 1 gives seg=0; digit 0 gives 7'h6D. With `data`=16'h0000, digit 0 gives 7'h3F.
- `load` on the exact boundary cycle: the new data appears in that frame and `pending` never rises.
- `en` toggled 1→0→1: blanked while low; restart gives `frame_start` and digit 0 at count 0.
- `Aclr` pulsed low mid-slot with `pending`=1: all outputs take their reset values asynchronously, `pending`=0, and the display shows 0 after `en`.

Source files
------------

// File: rtl/ssd_pkg.sv
// ============================================================================
// Module  : ssd_pkg
// Purpose : Shared glyph table, segment indices and COM polarity helper for
//           the multiplexed seven-segment scan driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Bit i of each entry lights segment i (a = bit 0 ... g = bit 6).
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic COM_INACTIVE_AL = 1'b1;
  localparam logic COM_INACTIVE_AH = 1'b0;

  function automatic logic com_inactive(input bit active_low);
    return active_low ? COM_INACTIVE_AL : COM_INACTIVE_AH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
// ============================================================================
// Module  : ssd_hex_decoder
// Purpose : Combinational hex nibble to seven-segment decode with blanking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? 7'h00 : HEX_SEG[nibble_i];
  end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// ============================================================================
// Module  : ssd_scan_driver
// Purpose : Multiplexed seven-segment scanner with prescaler, dead time,
//           leading-zero suppression and frame-coherent double buffering.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int DEAD           = 8,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                Clk,
  input  logic                Aclr,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                load,
  input  logic                en,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   COM,
  output logic [6:0]          seg,
  output logic                dp_out,
  output logic                pending,
  output logic                frame_start
);

  localparam int   PW      = $clog2(PRESCALE);
  localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic COM_OFF = com_inactive(COM_ACTIVE_LOW);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_data_q, stg_data_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic                frame_start_q, frame_start_d;

  logic                boundary;
  logic                active;
  logic [4*DIGITS-1:0] show_data;
  logic [DIGITS-1:0]   show_dp;
  logic [DIGITS-1:0]   supp;
  logic                zeros_above;
  logic [3:0]          nibble;
  logic                blank;

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    stg_data_d    = stg_data_q;
    stg_dp_d      = stg_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = pending_q;
    supp          = '0;
    zeros_above   = 1'b1;
    nibble        = 4'h0;
    dp_out_d      = 1'b0;
    com_d         = {DIGITS{COM_OFF}};

    // First cycle of a frame (also the en 0->1 restart, as state is held at 0).
    boundary      = en && (presc_q == '0) && (idx_q == '0);
    active        = en && (presc_q >= PW'(DEAD));
    frame_start_d = boundary;

    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (load) begin
      stg_data_d = data;
      stg_dp_d   = dp;
    end

    if (boundary) begin
      if (load) begin
        disp_data_d = data;
        disp_dp_d   = dp;
      end else if (pending_q) begin
        disp_data_d = stg_data_q;
        disp_dp_d   = stg_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    // The boundary cycle already shows the new frame's data.
    show_data = boundary ? disp_data_d : disp_data_q;
    show_dp   = boundary ? disp_dp_d   : disp_dp_q;

    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above & (show_data[4*i +: 4] == 4'h0);
      supp[i]     = zeros_above;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble   = show_data[4*i +: 4];
        dp_out_d = active & show_dp[i];
        com_d[i] = active ? ~COM_OFF : COM_OFF;
      end
    end

    blank = !active || (lz_en && |(supp & (DIGITS'(1) << idx_q)));
  end

  ssd_hex_decoder u_dec (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (seg_d)
  );

  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      presc_q       <= '0;
      idx_q         <= '0;
      stg_data_q    <= '0;
      stg_dp_q      <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      com_q         <= {DIGITS{COM_OFF}};
      seg_q         <= 7'h00;
      dp_out_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      stg_data_q    <= stg_data_d;
      stg_dp_q      <= stg_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      com_q         <= com_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign COM         = com_q;
  assign seg         = seg_q;
  assign dp_out      = dp_out_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// ============================================================================
// Module  : tb_ssd_scan_driver
// Purpose : Directed, scoreboard-based check of ssd_scan_driver (4 digits).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ssd_scan_driver;

  localparam int DIGITS = 4;
  localparam int PRESC  = 16;
  localparam int DEADT  = 2;
  localparam int FRAME  = DIGITS * PRESC;

  typedef struct packed {
    logic [3:0] com;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       fs;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Aclr = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  COM;
  logic [6:0]  seg;
  logic        dp_out;
  logic        pending;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  int          m_t;
  logic [15:0] m_stage, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;

  ssd_scan_driver #(
    .DIGITS         (DIGITS),
    .PRESCALE       (PRESC),
    .DEAD           (DEADT),
    .COM_ACTIVE_LOW (1'b1)
  ) dut (
    .Clk         (Clk),
    .Aclr        (Aclr),
    .data        (data),
    .dp          (dp),
    .load        (load),
    .en          (en),
    .lz_en       (lz_en),
    .COM         (COM),
    .seg         (seg),
    .dp_out      (dp_out),
    .pending     (pending),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic suppressed(input logic [15:0] d, input int dig, input logic lz);
    if (!lz || dig == 0) return 1'b0;
    for (int j = dig; j < DIGITS; j++)
      if (d[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_stage = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, predict the registered outputs, then compare after the edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
    exp_t e, got;
    int   cnt, dig;
    logic bnd, act;
    load = ld; data = d; dp = p;
    bnd = en && (m_t == 0);
    if (bnd) begin
      if (ld) begin
        m_disp = d; m_ddp = p;
      end else if (m_pend) begin
        m_disp = m_stage; m_ddp = m_sdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    if (ld) begin
      m_stage = d; m_sdp = p;
    end
    cnt = m_t % PRESC;
    dig = m_t / PRESC;
    act = en && (cnt >= DEADT);
    e.com  = act ? ~(4'b0001 << dig) : 4'b1111;
    e.seg  = (act && !suppressed(m_disp, dig, lz_en)) ? glyph(m_disp[4*dig +: 4]) : 7'h00;
    e.dp   = act ? m_ddp[dig] : 1'b0;
    e.pend = m_pend;
    e.fs   = bnd;
    m_t    = en ? (m_t + 1) % FRAME : 0;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    load = 1'b0;
    got = sb.pop_front();
    chk("COM", {28'h0, COM}, {28'h0, got.com});
    chk("seg", {25'h0, seg}, {25'h0, got.seg});
    chk("dp_out", {31'h0, dp_out}, {31'h0, got.dp});
    chk("pending", {31'h0, pending}, {31'h0, got.pend});
    chk("frame_start", {31'h0, frame_start}, {31'h0, got.fs});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'hDEAD, 4'b0000);
  endtask

  task automatic run_to(input int t);
    for (int k = 0; k < FRAME && m_t != t; k++) step(1'b0, 16'hBEEF, 4'b0000);
    chk("run_to_reached", m_t, t);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_COM"}, {28'h0, COM}, 32'hF);
    chk({tag, "_seg"}, {25'h0, seg}, 32'h0);
    chk({tag, "_dp_out"}, {31'h0, dp_out}, 32'h0);
    chk({tag, "_pending"}, {31'h0, pending}, 32'h0);
    chk({tag, "_frame_start"}, {31'h0, frame_start}, 32'h0);
  endtask

  initial begin
    model_reset();
    #2 Aclr = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs("reset_held");
    Aclr = 1'b1;

    // Load while disabled: pending rises and holds, outputs stay blank.
    step(1'b1, 16'h1234, 4'b0000);
    run(5);
    en = 1'b1;
    run(2 * FRAME + 3);

    // Mid-frame load: old value shown until the next frame.
    run_to(20);
    step(1'b1, 16'h00A5, 4'b0001);
    run(FRAME + 10);

    // Leading-zero suppression, decimal points on suppressed digits.
    lz_en = 1'b1;
    step(1'b1, 16'h0005, 4'b1010);
    run(2 * FRAME);
    step(1'b1, 16'h0000, 4'b0000);
    run(2 * FRAME);
    step(1'b1, 16'h0F00, 4'b0000);
    run(2 * FRAME);
    lz_en = 1'b0;

    // Load on the boundary cycle goes straight to the display.
    run_to(0);
    step(1'b1, 16'h9876, 4'b0100);
    chk("boundary_load_pending", {31'h0, pending}, 32'h0);
    run(FRAME + 2);

    // Repeated loads before a boundary: last one wins.
    run_to(40);
    step(1'b1, 16'hCDEF, 4'b0000);
    run(3);
    step(1'b1, 16'h8BA0, 4'b1111);
    run(FRAME);

    // Disable mid-slot, then restart.
    run_to(37);
    en = 1'b0;
    step(1'b1, 16'h4321, 4'b0010);
    run(12);
    en = 1'b1;
    run(FRAME + 4);

    // Asynchronous reset mid-slot with data pending.
    run_to(25);
    step(1'b1, 16'h7777, 4'b1111);
    run(3);
    chk("pending_before_reset", {31'h0, pending}, 32'h1);
    #2 Aclr = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(posedge Clk);
    @(negedge Clk);
    model_reset();
    Aclr = 1'b1;
    run(FRAME + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
